refresh_scheduler: RTL

Refresh scheduler for an array of `NUM_BANKS` gain-cell DRAM wrappers (128x64 each). It issues periodic refresh operations to the banks in round-robin order. For each operation it selects one target bank and its data-source partner bank, pulses the wrapper's self-refresh start, holds the refresh enables, and waits for the bank's `ref_done`. It sits between the top-level controller and the wrapper array, and it enforces the retention interval with a watchdog and deadline reporting.

---
 rtl/refresh_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/refresh_scheduler.sv
// Round-robin refresh scheduler for an array of gain-cell DRAM wrappers.
// Periodic requests are serviced one bank at a time, guarded by a watchdog and deadline flag.
module refresh_scheduler #(
    parameter int NUM_BANKS = 4,
    parameter int INTERVAL  = 1024,
    parameter int TIMEOUT   = 512,
    parameter int BW        = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic [NUM_BANKS-1:0] ref_done,
    output logic [NUM_BANKS-1:0] start_sr,
    output logic [NUM_BANKS-1:0] ref_en_current,
    output logic [NUM_BANKS-1:0] ref_en_old,
    output logic                 busy,
    output logic [BW-1:0]        cur_bank,
    output logic                 deadline_miss,
    output logic                 timeout_err
);

    localparam int CW = $clog2(INTERVAL);
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] START  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [CW-1:0] CNT_LAST  = CW'(INTERVAL - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(NUM_BANKS - 1);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pending_reg, pending_next;
    logic [WW-1:0] wd_reg, wd_next;
    logic [BW-1:0] cur_bank_reg, cur_bank_next;
    logic          deadline_miss_reg, deadline_miss_next;
    logic          timeout_err_reg, timeout_err_next;

    logic          wrap;
    logic          take;
    logic          timeout_set;
    logic [BW-1:0] partner_bank;

    always_comb begin
        wrap        = enable && (cnt_reg == CNT_LAST);
        take        = (state_reg == IDLE) && pending_reg && enable;
        timeout_set = 1'b0;

        cnt_next = enable ? (wrap ? '0 : cnt_reg + CW'(1)) : '0;

        // A fresh wrap re-arms pending even on the edge that consumes the old request.
        if (!enable) begin
            pending_next = 1'b0;
        end else if (wrap) begin
            pending_next = 1'b1;
        end else if (take) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending_reg;
        end

        state_next    = state_reg;
        wd_next       = wd_reg;
        cur_bank_next = cur_bank_reg;

        case (state_reg)
            IDLE: begin
                if (take) begin
                    state_next = START;
                end
            end
            START: begin
                wd_next    = '0;
                state_next = ACTIVE;
            end
            ACTIVE: begin
                wd_next = wd_reg + WW'(1);
                if (ref_done[cur_bank_reg]) begin
                    state_next = FINISH;
                end else if (wd_reg == WD_LAST) begin
                    state_next  = FINISH;
                    timeout_set = 1'b1;
                end
            end
            default: begin
                cur_bank_next = (cur_bank_reg == BANK_LAST) ? '0 : cur_bank_reg + BW'(1);
                state_next    = IDLE;
            end
        endcase

        if (wrap && pending_reg && !take) begin
            deadline_miss_next = 1'b1;
        end else if (clear_err) begin
            deadline_miss_next = 1'b0;
        end else begin
            deadline_miss_next = deadline_miss_reg;
        end

        if (timeout_set) begin
            timeout_err_next = 1'b1;
        end else if (clear_err) begin
            timeout_err_next = 1'b0;
        end else begin
            timeout_err_next = timeout_err_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            pending_reg       <= 1'b0;
            wd_reg            <= '0;
            cur_bank_reg      <= '0;
            deadline_miss_reg <= 1'b0;
            timeout_err_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            pending_reg       <= pending_next;
            wd_reg            <= wd_next;
            cur_bank_reg      <= cur_bank_next;
            deadline_miss_reg <= deadline_miss_next;
            timeout_err_reg   <= timeout_err_next;
        end
    end

    // Partner bank supplies the data source for the target's refresh.
    assign partner_bank = (cur_bank_reg == '0) ? BANK_LAST : cur_bank_reg - BW'(1);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign start_sr[gi]       = (state_reg == START) && (cur_bank_reg == BW'(gi));
            assign ref_en_current[gi] = ((state_reg == START) || (state_reg == ACTIVE))
                                        && (cur_bank_reg == BW'(gi));
            assign ref_en_old[gi]     = ((state_reg == START) || (state_reg == ACTIVE))
                                        && (partner_bank == BW'(gi));
        end
    endgenerate

    assign busy          = (state_reg != IDLE);
    assign cur_bank      = cur_bank_reg;
    assign deadline_miss = deadline_miss_reg;
    assign timeout_err   = timeout_err_reg;

endmodule
